cv32e40p_uart_rx_mmio: RTL and testbench



---
 rtl/cv32e40p_uart_pkg.sv | 21 ++
 rtl/uart_rx.sv | 103 ++++++++++
 rtl/cv32e40p_uart_rx_mmio.sv | 123 ++++++++++++
 tb/tb_cv32e40p_uart_rx_mmio.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_uart_pkg.sv
// Shared constants for the debug UART receive path: register addresses,
// STATUS bit positions and the receiver state encoding.
package cv32e40p_uart_pkg;

    localparam logic [31:0] RXDATA_ADDR = 32'h1000_0004;
    localparam logic [31:0] STATUS_ADDR = 32'h1000_0008;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 deserialiser: two-flop input synchroniser plus a mid-bit sampling FSM.
// Emits one-cycle pulses for a completed byte or a frame (stop bit) error.
module uart_rx
    import cv32e40p_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       rx_frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_line;

    assign rx_line = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_d          = bit_q;
        shift_d        = shift_q;
        rx_valid_o     = 1'b0;
        rx_frame_err_o = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_line) begin
                    state_d = RX_START;
                    cnt_d   = CNT_HALF;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    // A start bit that is high again at mid-bit was only a glitch
                    if (rx_line) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                        cnt_d   = CNT_FULL;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_line, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    rx_valid_o     = rx_line;
                    rx_frame_err_o = !rx_line;
                    state_d        = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte_o = shift_q;

endmodule

// File: rtl/cv32e40p_uart_rx_mmio.sv
// Debug UART receive path as a data-bus slave: RX FIFO, sticky error flags,
// RXDATA/STATUS decode. Define UART_RX_IRQ_EN to add the irq_rx_o output.
module cv32e40p_uart_rx_mmio
    import cv32e40p_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_rvalid_o,
    input  logic        uart_rx_i
`ifdef UART_RX_IRQ_EN
    ,
    output logic        irq_rx_o
`endif
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int FIFO_W       = $clog2(FIFO_DEPTH);

    logic [7:0]        rx_byte;
    logic              rx_valid, rx_frame_err;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [FIFO_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic [31:0]       rdata_q, rdata_d, status_word;
    logic              rvalid_q;
    logic              hit_rx, hit_st, not_empty, full, push, pop;
    logic              unused_bus;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rx_i          (uart_rx_i),
        .rx_byte_o     (rx_byte),
        .rx_valid_o    (rx_valid),
        .rx_frame_err_o(rx_frame_err)
    );

    assign unused_bus = ^{data_be_i, data_wdata_i[31:4], data_wdata_i[1:0]};

    assign hit_rx    = data_req_i && (data_addr_i == RXDATA_ADDR);
    assign hit_st    = data_req_i && (data_addr_i == STATUS_ADDR);
    assign not_empty = (count_q != '0);
    assign full      = (count_q == (FIFO_W + 1)'(FIFO_DEPTH));
    assign pop       = hit_rx && !data_we_i && not_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign push      = rx_valid && (!full || pop);

    always_comb begin
        status_word                              = '0;
        status_word[ST_NOT_EMPTY]                = not_empty;
        status_word[ST_FULL]                     = full;
        status_word[ST_OVERRUN]                  = overrun_q;
        status_word[ST_FRAME_ERR]                = frame_err_q;
        status_word[ST_COUNT_LSB +: FIFO_W + 1]  = count_q;
    end

    always_comb begin
        rdata_d = '0;
        if (hit_rx && !data_we_i && not_empty) begin
            rdata_d = {23'b0, 1'b1, mem_q[rd_ptr_q]};
        end else if (hit_st && !data_we_i) begin
            rdata_d = status_word;
        end
        count_d     = count_q + (FIFO_W + 1)'(push) - (FIFO_W + 1)'(pop);
        // Set terms are ORed last so a new error beats a same-cycle clear
        overrun_d   = (overrun_q && !(hit_st && data_we_i && data_wdata_i[ST_OVERRUN]))
                      || (rx_valid && full && !pop);
        frame_err_d = (frame_err_q && !(hit_st && data_we_i && data_wdata_i[ST_FRAME_ERR]))
                      || rx_frame_err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= hit_rx || hit_st;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= rx_byte;
    end

    assign data_rdata_o  = rdata_q;
    assign data_rvalid_o = rvalid_q;

`ifdef UART_RX_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) irq_q <= 1'b0;
        else       irq_q <= not_empty || overrun_q || frame_err_q;
    end

    assign irq_rx_o = irq_q;
`endif

endmodule

// File: tb/tb_cv32e40p_uart_rx_mmio.sv
// Directed bench for cv32e40p_uart_rx_mmio at 10 clocks per bit; checks bus
// responses, FIFO order, sticky flags, glitch rejection and mid-frame reset.
module tb_cv32e40p_uart_rx_mmio;

    localparam int CPB = 10;
    localparam logic [31:0] A_RX  = 32'h1000_0004;
    localparam logic [31:0] A_ST  = 32'h1000_0008;
    localparam logic [31:0] A_BAD = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'hF;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        uart_rx = 1'b1;
`ifdef UART_RX_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cv32e40p_uart_rx_mmio #(
        .CLK_FREQ_HZ(10_000_000),
        .BAUD_RATE  (1_000_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_req_i   (req),
        .data_addr_i  (addr),
        .data_we_i    (we),
        .data_be_i    (be),
        .data_wdata_i (wdata),
        .data_rdata_o (rdata),
        .data_rvalid_o(rvalid),
        .uart_rx_i    (uart_rx)
`ifdef UART_RX_IRQ_EN
        ,
        .irq_rx_o     (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit plus eight data bits, LSB first; leaves the caller at the stop bit
    task automatic drive_bits(input logic [7:0] b);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bits(b);
        uart_rx = stop;
        tick(CPB);
        uart_rx = 1'b1;
        tick(CPB);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        req  = 1'b1;
        addr = a;
        we   = 1'b0;
        tick(1);
        d    = rdata;
        v    = rvalid;
        req  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        bus_read(a, d, v);
        check(tag, d, exp);
        check({tag, "_rvalid"}, {31'b0, v}, 32'd1);
    endtask

    task automatic bus_write(input string tag, input logic [31:0] a, input logic [31:0] w);
        req   = 1'b1;
        addr  = a;
        we    = 1'b1;
        wdata = w;
        tick(1);
        check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
        check({tag, "_rdata"}, rdata, 32'd0);
        req   = 1'b0;
        we    = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        v;

        tick(3);
        check("reset_rdata", rdata, 32'd0);
        check("reset_rvalid", {31'b0, rvalid}, 32'd0);
`ifdef UART_RX_IRQ_EN
        check("reset_irq", {31'b0, irq}, 32'd0);
`endif
        rst = 1'b0;
        tick(2);
        read_check("status_init", A_ST, 32'h0000_0000);
        bus_read(A_BAD, d, v);
        check("miss_rvalid", {31'b0, v}, 32'd0);
        check("miss_rdata", d, 32'd0);

        send_byte(8'hA5, 1'b1);
        read_check("rx_a5", A_RX, 32'h0000_01A5);
        read_check("rx_empty", A_RX, 32'h0000_0000);
        read_check("status_after_a5", A_ST, 32'h0000_0000);

        for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b1);
        read_check("status_overrun", A_ST, 32'h0000_0107);
        for (int i = 0; i < 16; i++) read_check($sformatf("drain_%0d", i), A_RX, 32'h100 | i);
        read_check("status_drained", A_ST, 32'h0000_0004);
        bus_write("clr_ovr", A_ST, 32'h4);
        read_check("status_ovr_clr", A_ST, 32'h0000_0000);

        send_byte(8'h3C, 1'b0);
        tick(CPB);
        read_check("status_ferr", A_ST, 32'h0000_0008);
`ifdef UART_RX_IRQ_EN
        check("irq_ferr", {31'b0, irq}, 32'd1);
`endif
        bus_write("clr_ferr", A_ST, 32'h8);
        read_check("status_ferr_clr", A_ST, 32'h0000_0000);
`ifdef UART_RX_IRQ_EN
        tick(2);
        check("irq_clr", {31'b0, irq}, 32'd0);
`endif

        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(2 * CPB);
        read_check("status_glitch", A_ST, 32'h0000_0000);
        send_byte(8'h55, 1'b1);
        read_check("rx_55", A_RX, 32'h0000_0155);

        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1);
        read_check("status_full", A_ST, 32'h0000_0103);
        // The 17th byte is pushed at the edge that accepts this read
        drive_bits(8'h30);
        uart_rx = 1'b1;
        tick(7);
        read_check("rx_overlap", A_RX, 32'h0000_0120);
        tick(CPB);
        read_check("status_overlap", A_ST, 32'h0000_0103);
        for (int i = 1; i < 16; i++) read_check($sformatf("order_%0d", i), A_RX, 32'h120 + i);
        read_check("order_last", A_RX, 32'h0000_0130);
        read_check("status_order", A_ST, 32'h0000_0000);

        send_byte(8'h11, 1'b1);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            uart_rx = (i != 0);
            tick(CPB);
        end
        rst     = 1'b1;
        uart_rx = 1'b1;
        tick(1);
        rst     = 1'b0;
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_rvalid", {31'b0, rvalid}, 32'd0);
`ifdef UART_RX_IRQ_EN
        check("midrst_irq", {31'b0, irq}, 32'd0);
`endif
        tick(3 * CPB);
        read_check("status_midrst", A_ST, 32'h0000_0000);
        send_byte(8'h81, 1'b1);
        read_check("rx_81", A_RX, 32'h0000_0181);
        read_check("status_end", A_ST, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
